// File: rtl/mmio_pkg.sv
// Shared constants for the memory-mapped I/O block: register map, status bit layout, miss value.
package mmio_pkg;

    localparam logic [15:0] MMIO_KDATA = 16'hFFF0;
    localparam logic [15:0] MMIO_SDATA = 16'hFFF2;
    localparam logic [15:0] MMIO_KCTRL = 16'hFFF4;
    localparam logic [15:0] MMIO_SCTRL = 16'hFFF6;
    localparam logic [15:0] MMIO_HEX   = 16'hFFF8;
    localparam logic [15:0] MMIO_LEDR  = 16'hFFFA;
    localparam logic [15:0] MMIO_LEDG  = 16'hFFFC;
    localparam logic [15:0] MMIO_TCNT  = 16'hFFFE;
    localparam logic [15:0] MMIO_DEAD  = 16'hDEAD;

    localparam int unsigned RDY_BIT = 0;
    localparam int unsigned OVR_BIT = 1;

    typedef struct packed {
        logic ovr;
        logic rdy;
    } mmio_stat_t;

    // Priority: software clears, then RE clear, then a new accepted value sets (set wins).
    function automatic mmio_stat_t stat_next(input mmio_stat_t cur, input logic wr_clr,
                                             input logic [1:0] wbits, input logic rd_clr,
                                             input logic chg);
        mmio_stat_t nxt;
        nxt = cur;
        if (wr_clr) begin
            nxt.rdy = cur.rdy & wbits[RDY_BIT];
            nxt.ovr = cur.ovr & wbits[OVR_BIT];
        end
        if (rd_clr) nxt.rdy = 1'b0;
        if (chg) begin
            nxt.rdy = 1'b1;
            if (cur.rdy) nxt.ovr = 1'b1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/mmio_io_ctrl_if.sv
// CPU data-memory side bus of the I/O block; master = CPU, slave = mmio_io_ctrl.
interface mmio_io_ctrl_if #(
    parameter int unsigned DBITS = 16
);
    logic [DBITS-1:0] ADDR;
    logic [DBITS-1:0] WDATA;
    logic             WE;
    logic             RE;
    logic [DBITS-1:0] DOUT;
    logic             SEL;

    modport master (output ADDR, output WDATA, output WE, output RE, input DOUT, input SEL);
    modport slave  (input ADDR, input WDATA, input WE, input RE, output DOUT, output SEL);
endinterface

// File: rtl/mmio_debounce.sv
// Two-flop synchroniser plus stability counter; accepts a new value after CYC steady cycles
// and emits a one-cycle 'changed' pulse coincident with the load.
module mmio_debounce #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CYC   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] value,
    output logic             changed
);
    localparam int unsigned CW = (CYC > 2) ? $clog2(CYC) : 1;

    logic [WIDTH-1:0] s1, s2, s3;
    logic [CW-1:0]    cnt;
    logic             stable_new;
    logic             hit;

    // s3 is the synced value from the previous cycle; any change restarts the count.
    assign stable_new = (s2 != value) && (s2 == s3);
    assign hit        = stable_new && (cnt == CW'(CYC - 2));
    assign changed    = hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1    <= '0;
            s2    <= '0;
            s3    <= '0;
            cnt   <= '0;
            value <= '0;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
            if (!stable_new || hit) cnt <= '0;
            else                    cnt <= cnt + 1'b1;
            if (hit) value <= s2;
        end
    end

endmodule

// File: rtl/mmio_io_ctrl.sv
// Memory-mapped I/O for the 16-bit CPU: HEX/LEDR/LEDG outputs, debounced KEY/SW with status.
// Optional timer register at FFFE when MMIO_TIMER_EN is defined.
module mmio_io_ctrl
    import mmio_pkg::*;
#(
    parameter int unsigned DBITS        = 16,
    parameter int unsigned DEBOUNCE_CYC = 500000,
    parameter int unsigned TICK_CYC     = 50000
) (
    input  logic                clk,
    input  logic                reset,
    mmio_io_ctrl_if.slave       bus,
    input  logic [3:0]          KEY_IN,
    input  logic [9:0]          SW_IN,
    output logic [15:0]         HEX_OUT,
    output logic [9:0]          LEDR_OUT,
    output logic [7:0]          LEDG_OUT
);
    if (DEBOUNCE_CYC < 2 || TICK_CYC < 1 || DBITS < 16) begin : g_bad_cfg
        $error("mmio_io_ctrl: unsupported parameter combination");
    end

    logic [3:0] kdata;
    logic [9:0] sdata;
    logic       k_chg, s_chg;
    mmio_stat_t kstat, sstat;

    // Keys are inverted before synchronising, so a cleared synchroniser means "released".
    mmio_debounce #(.WIDTH(4), .CYC(DEBOUNCE_CYC)) u_key (
        .clk(clk), .reset(reset), .din(~KEY_IN), .value(kdata), .changed(k_chg)
    );
    mmio_debounce #(.WIDTH(10), .CYC(DEBOUNCE_CYC)) u_sw (
        .clk(clk), .reset(reset), .din(SW_IN), .value(sdata), .changed(s_chg)
    );

`ifdef MMIO_TIMER_EN
    localparam int unsigned PW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
    logic [15:0]   tcnt;
    logic [PW-1:0] pre;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcnt <= '0;
            pre  <= '0;
        end else if (bus.WE && bus.ADDR == DBITS'(MMIO_TCNT)) begin
            tcnt <= bus.WDATA[15:0];
            pre  <= '0;
        end else if (pre == PW'(TICK_CYC - 1)) begin
            tcnt <= tcnt + 1'b1;
            pre  <= '0;
        end else begin
            pre <= pre + 1'b1;
        end
    end
`endif

    always_comb begin
        bus.SEL  = 1'b1;
        bus.DOUT = '0;
        case (bus.ADDR)
            DBITS'(MMIO_KDATA): bus.DOUT = DBITS'(kdata);
            DBITS'(MMIO_SDATA): bus.DOUT = DBITS'(sdata);
            DBITS'(MMIO_KCTRL): bus.DOUT = DBITS'(kstat);
            DBITS'(MMIO_SCTRL): bus.DOUT = DBITS'(sstat);
            DBITS'(MMIO_HEX):   bus.DOUT = DBITS'(HEX_OUT);
            DBITS'(MMIO_LEDR):  bus.DOUT = DBITS'(LEDR_OUT);
            DBITS'(MMIO_LEDG):  bus.DOUT = DBITS'(LEDG_OUT);
`ifdef MMIO_TIMER_EN
            DBITS'(MMIO_TCNT):  bus.DOUT = DBITS'(tcnt);
`endif
            default: begin
                bus.SEL  = 1'b0;
                bus.DOUT = DBITS'(MMIO_DEAD);
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            HEX_OUT  <= '0;
            LEDR_OUT <= '0;
            LEDG_OUT <= '0;
            kstat    <= '0;
            sstat    <= '0;
        end else begin
            if (bus.WE) begin
                case (bus.ADDR)
                    DBITS'(MMIO_HEX):  HEX_OUT  <= bus.WDATA[15:0];
                    DBITS'(MMIO_LEDR): LEDR_OUT <= bus.WDATA[9:0];
                    DBITS'(MMIO_LEDG): LEDG_OUT <= bus.WDATA[7:0];
                    default: ;
                endcase
            end
            kstat <= stat_next(kstat, bus.WE && bus.ADDR == DBITS'(MMIO_KCTRL), bus.WDATA[1:0],
                               bus.RE && bus.ADDR == DBITS'(MMIO_KDATA), k_chg);
            sstat <= stat_next(sstat, bus.WE && bus.ADDR == DBITS'(MMIO_SCTRL), bus.WDATA[1:0],
                               bus.RE && bus.ADDR == DBITS'(MMIO_SDATA), s_chg);
        end
    end

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Directed bench for mmio_io_ctrl (DEBOUNCE_CYC=4, TICK_CYC=3); define MMIO_TIMER_EN to cover the timer.
module tb_mmio_io_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] KEY_IN;
    logic [9:0] SW_IN;
    logic [15:0] HEX_OUT;
    logic [9:0]  LEDR_OUT;
    logic [7:0]  LEDG_OUT;

    int n_cmp = 0;
    int n_err = 0;

    mmio_io_ctrl_if #(.DBITS(16)) bus ();

    mmio_io_ctrl #(.DBITS(16), .DEBOUNCE_CYC(4), .TICK_CYC(3)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .KEY_IN(KEY_IN), .SW_IN(SW_IN),
        .HEX_OUT(HEX_OUT), .LEDR_OUT(LEDR_OUT), .LEDG_OUT(LEDG_OUT)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [15:0] a, input logic [15:0] exp,
                      input logic exp_sel);
        bus.ADDR = a;
        #1;
        check(tag, bus.DOUT, exp);
        check({tag, "_sel"}, {15'd0, bus.SEL}, {15'd0, exp_sel});
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        bus.ADDR = a; bus.WDATA = d; bus.WE = 1'b1;
        @(negedge clk);
        bus.WE = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit found;
        reset = 1'b1; KEY_IN = 4'hF; SW_IN = '0;
        bus.ADDR = '0; bus.WDATA = '0; bus.WE = 1'b0; bus.RE = 1'b0;
        cycles(3);
        reset = 1'b0;
        cycles(1);

        // Reset state
        check("rst_hex", HEX_OUT, 16'h0000);
        check("rst_ledr", {6'd0, LEDR_OUT}, 16'h0000);
        check("rst_ledg", {8'd0, LEDG_OUT}, 16'h0000);
        rd("rst_kdata", 16'hFFF0, 16'h0000, 1'b1);
        rd("rst_sdata", 16'hFFF2, 16'h0000, 1'b1);
        rd("rst_kctrl", 16'hFFF4, 16'h0000, 1'b1);
        rd("rst_sctrl", 16'hFFF6, 16'h0000, 1'b1);

        // 1: output registers
        wr(16'hFFF8, 16'h1234);
        wr(16'hFFFA, 16'h03FF);
        wr(16'hFFFC, 16'h00A5);
        check("hex_out", HEX_OUT, 16'h1234);
        check("ledr_out", {6'd0, LEDR_OUT}, 16'h03FF);
        check("ledg_out", {8'd0, LEDG_OUT}, 16'h00A5);
        rd("rd_hex", 16'hFFF8, 16'h1234, 1'b1);
        rd("rd_ledr", 16'hFFFA, 16'h03FF, 1'b1);
        rd("rd_ledg", 16'hFFFC, 16'h00A5, 1'b1);

        // 2: switch debounce, exact acceptance point, then a short glitch
        SW_IN = 10'h2AA;
        cycles(5);
        rd("sw_early", 16'hFFF2, 16'h0000, 1'b1);
        rd("sw_early_ctrl", 16'hFFF6, 16'h0000, 1'b1);
        cycles(1);
        rd("sw_data", 16'hFFF2, 16'h02AA, 1'b1);
        rd("sw_ctrl", 16'hFFF6, 16'h0001, 1'b1);
        SW_IN = 10'h000;
        cycles(2);
        SW_IN = 10'h2AA;
        cycles(8);
        rd("sw_glitch_data", 16'hFFF2, 16'h02AA, 1'b1);
        rd("sw_glitch_ctrl", 16'hFFF6, 16'h0001, 1'b1);

        // 3: key press/release, overrun, write-zero-to-clear
        KEY_IN = 4'b1110;
        cycles(8);
        rd("key_press", 16'hFFF0, 16'h0001, 1'b1);
        rd("key_press_ctrl", 16'hFFF4, 16'h0001, 1'b1);
        KEY_IN = 4'hF;
        cycles(8);
        rd("key_rel", 16'hFFF0, 16'h0000, 1'b1);
        rd("key_rel_ctrl", 16'hFFF4, 16'h0003, 1'b1);
        wr(16'hFFF4, 16'h0001);
        rd("kctrl_wr1", 16'hFFF4, 16'h0001, 1'b1);
        wr(16'hFFF6, 16'h0000);
        rd("sctrl_wr0", 16'hFFF6, 16'h0000, 1'b1);

        // 4: RE coincident with an accepted change -> set wins; RE alone then clears RDY
        bus.ADDR = 16'hFFF0; bus.RE = 1'b1;
        KEY_IN = 4'b1101;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (bus.DOUT == 16'h0002) found = 1'b1;
        end
        bus.RE = 1'b0;
        check("re_race_seen", {15'd0, found}, 16'h0001);
        rd("re_race_data", 16'hFFF0, 16'h0002, 1'b1);
        rd("re_race_ctrl", 16'hFFF4, 16'h0001, 1'b1);
        @(negedge clk);
        bus.ADDR = 16'hFFF0; bus.RE = 1'b1;
        @(negedge clk);
        bus.RE = 1'b0;
        rd("re_clear_ctrl", 16'hFFF4, 16'h0000, 1'b1);
        rd("re_keeps_data", 16'hFFF0, 16'h0002, 1'b1);

        // 5: unmapped and read-only addresses
        rd("unmapped_0100", 16'h0100, 16'hDEAD, 1'b0);
        rd("unmapped_ffee", 16'hFFEE, 16'hDEAD, 1'b0);
        wr(16'hFFF0, 16'h5555);
        rd("ro_kdata", 16'hFFF0, 16'h0002, 1'b1);
        wr(16'hFFF2, 16'h0155);
        rd("ro_sdata", 16'hFFF2, 16'h02AA, 1'b1);
        wr(16'h0100, 16'hABCD);
        check("unmapped_wr_hex", HEX_OUT, 16'h1234);
        check("unmapped_wr_ledr", {6'd0, LEDR_OUT}, 16'h03FF);
        check("unmapped_wr_ledg", {8'd0, LEDG_OUT}, 16'h00A5);

        // 6: timer
`ifdef MMIO_TIMER_EN
        wr(16'hFFFE, 16'hFFFF);
        rd("tcnt_load", 16'hFFFE, 16'hFFFF, 1'b1);
        cycles(2);
        rd("tcnt_hold", 16'hFFFE, 16'hFFFF, 1'b1);
        cycles(1);
        rd("tcnt_wrap", 16'hFFFE, 16'h0000, 1'b1);
`else
        rd("tcnt_absent", 16'hFFFE, 16'hDEAD, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
